// File: rtl/eight_by_four_divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_states_defines
// Shared definitions for the eight_by_four_divider block: the FSM state
// encoding, the default operand widths and the quotient value reported on a
// divide by zero.
// Ports: none (package).
// -----------------------------------------------------------------------------
package divider_states_defines;

  localparam int DEF_N_W = 8;
  localparam int DEF_D_W = 4;

  // Wide enough for any supported N_W; the top slices off what it needs.
  localparam logic [31:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    END   = 2'd3
  } state_t;

endpackage

// File: rtl/eight_by_four_divider_controller.sv
// -----------------------------------------------------------------------------
// divider_controller
// Sequencer for the restoring divider: state register, iteration counter and
// next-state logic.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for ena; operands are captured by the datapath here
//   CHECK | divisor inspected; zero divisor skips straight to END
//   ITER  | one quotient bit per cycle, N_W cycles
//   END   | datapath writes Q/R/done, then back to IDLE
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   ena          start request (only acted on in IDLE)
//   d_zero       captured divisor equals zero
//   state_o      current state
//   last_iter_o  high during the final ITER cycle
// -----------------------------------------------------------------------------
module divider_controller
  import divider_states_defines::*;
#(
  parameter int N_W = DEF_N_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   d_zero,
  output state_t state_o,
  output logic   last_iter_o
);

  localparam int CNT_W = $clog2(N_W);

  state_t             curr_state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      curr_state <= IDLE;
      cnt        <= '0;
    end else begin
      curr_state <= next_state;
      // Counter only runs in ITER, so it is already zero on entry.
      if (curr_state == ITER) cnt <= cnt + CNT_W'(1);
      else                    cnt <= '0;
    end
  end

  assign last_iter_o = (curr_state == ITER) && (cnt == CNT_W'(N_W - 1));
  assign state_o     = curr_state;

  always_comb begin
    next_state = IDLE;
    case (curr_state)
      IDLE:    next_state = ena ? CHECK : IDLE;
      CHECK:   next_state = d_zero ? END : ITER;
      ITER:    next_state = last_iter_o ? END : ITER;
      END:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/eight_by_four_divider.sv
// -----------------------------------------------------------------------------
// eight_by_four_divider
// Multi-cycle restoring divider, N_W-bit dividend by D_W-bit divisor, one
// quotient bit per clock. Shares the ena/done/state handshake of the
// shift-and-add multiplier so the two are interchangeable at the board top.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   ena       start request, sampled in IDLE only
//   A         dividend, captured with ena
//   B         divisor, captured with ena
//   Q         quotient (all ones on divide by zero)
//   R         remainder (zero on divide by zero)
//   done      one-cycle completion pulse
//   div_zero  last operation had B == 0; held until next start
//   busy      FSM not in IDLE
//   state     debug state {2'b0, curr_state}
// -----------------------------------------------------------------------------
module eight_by_four_divider
  import divider_states_defines::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [N_W-1:0] A,
  input  logic [D_W-1:0] B,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           done,
  output logic           div_zero,
  output logic           busy,
  output logic [3:0]     state
);

  state_t         curr_state;
  logic           last_iter;
  logic [N_W-1:0] q_reg;
  logic [D_W-1:0] d_reg;
  logic [D_W:0]   rem_reg;
  logic           zero_flag;
  logic [D_W+1:0] trial;

  divider_controller #(.N_W(N_W)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .d_zero      (d_reg == '0),
    .state_o     (curr_state),
    .last_iter_o (last_iter)
  );

  // rem_reg[D_W] is always 0 (partial remainder stays below the divisor), so
  // using the whole register here equals zero-extending its low D_W bits.
  assign trial = {rem_reg, q_reg[N_W-1]} - {2'b00, d_reg};

  assign busy  = (curr_state != IDLE);
  assign state = {2'b00, curr_state};

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg     <= '0;
      d_reg     <= '0;
      rem_reg   <= '0;
      zero_flag <= 1'b0;
      Q         <= '0;
      R         <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (curr_state)
        IDLE: begin
          if (ena) begin
            q_reg     <= A;
            d_reg     <= B;
            rem_reg   <= '0;
            zero_flag <= 1'b0;
            div_zero  <= 1'b0;
          end
        end
        CHECK: begin
          if (d_reg == '0) zero_flag <= 1'b1;
        end
        ITER: begin
          // Restore on negative trial: keep the shifted remainder instead.
          if (!trial[D_W+1]) begin
            rem_reg <= trial[D_W:0];
            q_reg   <= {q_reg[N_W-2:0], 1'b1};
          end else begin
            rem_reg <= {rem_reg[D_W-1:0], q_reg[N_W-1]};
            q_reg   <= {q_reg[N_W-2:0], 1'b0};
          end
        end
        END: begin
          if (zero_flag) begin
            Q        <= DIV_ZERO_Q[N_W-1:0];
            R        <= '0;
            div_zero <= 1'b1;
          end else begin
            Q <= q_reg;
            R <= rem_reg[D_W-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_by_four_divider.sv
// -----------------------------------------------------------------------------
// tb_eight_by_four_divider
// Directed self-checking bench for eight_by_four_divider. Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_eight_by_four_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] A   = '0;
  logic [3:0] B   = '0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       done;
  logic       div_zero;
  logic       busy;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  eight_by_four_divider dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .done     (done),
    .div_zero (div_zero),
    .busy     (busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Starts one operation and waits for done. lat = edges from E0 to the sample
  // where done is seen; clean = busy stayed high until done and dropped with it.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output bit got, output bit clean);
    ena = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    ena = 1'b0;
    lat = 0; got = 1'b0; clean = 1'b1;
    while (!got && lat < 30) begin
      if (done) begin
        got = 1'b1;
        if (busy) clean = 1'b0;
      end else begin
        if (!busy) clean = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; A = 8'd200; B = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Q !== 8'd0)        begin errors++; $display("FAIL reset_q got %0d want 0", Q); end
    checks++; if (R !== 4'd0)        begin errors++; $display("FAIL reset_r got %0d want 0", R); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (state !== 4'd0)    begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    ena = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 4'd0)    begin errors++; $display("FAIL post_reset_state got %0d want 0", state); end
  endtask

  task automatic test_basic();
    int lat; bit got; bit clean;
    run_div(8'd200, 4'd7, lat, got, clean);
    checks++; if (got !== 1'b1)   begin errors++; $display("FAIL basic_done_seen got %b want 1", got); end
    checks++; if (lat !== 10)     begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
    checks++; if (clean !== 1'b1) begin errors++; $display("FAIL basic_busy_profile got %b want 1", clean); end
    checks++; if (Q !== 8'd28)    begin errors++; $display("FAIL basic_q got %0d want 28", Q); end
    checks++; if (R !== 4'd4)     begin errors++; $display("FAIL basic_r got %0d want 4", R); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_div_zero got %b want 0", div_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (Q !== 8'd28)    begin errors++; $display("FAIL basic_q_hold got %0d want 28", Q); end
  endtask

  task automatic test_values();
    logic [7:0] va [3] = '{8'd255, 8'd255, 8'd5};
    logic [3:0] vb [3] = '{4'd1,   4'd15,  4'd9};
    logic [7:0] vq [3] = '{8'd255, 8'd17,  8'd0};
    logic [3:0] vr [3] = '{4'd0,   4'd0,   4'd5};
    int lat; bit got; bit clean;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], lat, got, clean);
      checks++; if (lat !== 10) begin errors++; $display("FAIL values_latency[%0d] got %0d want 10", i, lat); end
      checks++; if (Q !== vq[i]) begin errors++; $display("FAIL values_q[%0d] got %0d want %0d", i, Q, vq[i]); end
      checks++; if (R !== vr[i]) begin errors++; $display("FAIL values_r[%0d] got %0d want %0d", i, R, vr[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit got; bit clean;
    run_div(8'd100, 4'd0, lat, got, clean);
    checks++; if (lat !== 2)         begin errors++; $display("FAIL dz_latency got %0d want 2", lat); end
    checks++; if (clean !== 1'b1)    begin errors++; $display("FAIL dz_busy_profile got %b want 1", clean); end
    checks++; if (Q !== 8'd255)      begin errors++; $display("FAIL dz_q got %0d want 255", Q); end
    checks++; if (R !== 4'd0)        begin errors++; $display("FAIL dz_r got %0d want 0", R); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold got %b want 1", div_zero); end
    run_div(8'd9, 4'd3, lat, got, clean);
    checks++; if (lat !== 10)        begin errors++; $display("FAIL dz_next_latency got %0d want 10", lat); end
    checks++; if (Q !== 8'd3)        begin errors++; $display("FAIL dz_next_q got %0d want 3", Q); end
    checks++; if (R !== 4'd0)        begin errors++; $display("FAIL dz_next_r got %0d want 0", R); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag got %b want 0", div_zero); end
  endtask

  task automatic test_back_to_back();
    int lat;
    ena = 1'b1; A = 8'd50; B = 4'd6;
    @(posedge clk); #1;
    A = 8'd77; B = 4'd5;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) begin A = 8'hFF; B = 4'h1; end
      if (lat == 6) begin A = 8'd77; B = 4'd5; end
    end
    checks++; if (lat !== 10)   begin errors++; $display("FAIL b2b_first_latency got %0d want 10", lat); end
    checks++; if (Q !== 8'd8)   begin errors++; $display("FAIL b2b_first_q got %0d want 8", Q); end
    checks++; if (R !== 4'd2)   begin errors++; $display("FAIL b2b_first_r got %0d want 2", R); end
    @(posedge clk); #1;
    ena = 1'b0;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL b2b_restart_state got %0d want 1", state); end
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat + 1 !== 11) begin errors++; $display("FAIL b2b_period got %0d want 11", lat + 1); end
    checks++; if (Q !== 8'd15)  begin errors++; $display("FAIL b2b_second_q got %0d want 15", Q); end
    checks++; if (R !== 4'd2)   begin errors++; $display("FAIL b2b_second_r got %0d want 2", R); end
  endtask

  task automatic test_reset_mid();
    int lat; bit got; bit clean;
    int pulses;
    ena = 1'b1; A = 8'd200; B = 4'd7;
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; ena = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; ena = 1'b0;
    checks++; if (state !== 4'd0)    begin errors++; $display("FAIL rmid_state got %0d want 0", state); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (Q !== 8'd0)        begin errors++; $display("FAIL rmid_q got %0d want 0", Q); end
    checks++; if (R !== 4'd0)        begin errors++; $display("FAIL rmid_r got %0d want 0", R); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL rmid_div_zero got %b want 0", div_zero); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_no_activity got %0d want 0", pulses); end
    run_div(8'd200, 4'd7, lat, got, clean);
    checks++; if (lat !== 10)   begin errors++; $display("FAIL rmid_restart_latency got %0d want 10", lat); end
    checks++; if (Q !== 8'd28)  begin errors++; $display("FAIL rmid_restart_q got %0d want 28", Q); end
    checks++; if (R !== 4'd4)   begin errors++; $display("FAIL rmid_restart_r got %0d want 4", R); end
  endtask

  task automatic test_sweep();
    int lat; bit got; bit clean;
    int qv, rv;
    bit ok;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(a[7:0], b[3:0], lat, got, clean);
        qv = int'(Q); rv = int'(R);
        if (!got)        ok = 1'b0;
        else if (b == 0) ok = (qv == 255) && (rv == 0) && (div_zero === 1'b1) && (lat == 2);
        else             ok = (qv * b + rv == a) && (rv < b) && (div_zero === 1'b0) && (lat == 10);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sweep a=%0d b=%0d got q=%0d r=%0d dz=%b lat=%0d want q*b+r=a r<b (b=0: q=255 r=0)",
                   a, b, qv, rv, div_zero, lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
